// File: rtl/alu_responder.sv
// Handshaked ALU responder: accepts one request, computes (iteratively for SLL),
// holds the response until consumed, and counts completed operations.
module alu_responder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [CNT_W-1:0] ops_done
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [SH_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0] ops_q, ops_d;

  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf;
  logic [SH_W-1:0]  shamt;
  logic             accept, is_shift;

  assign shamt    = req_b[SH_W-1:0];
  assign accept   = req_valid && (state_q == IDLE);
  assign is_shift = (req_op == 3'b101) && (shamt != '0);

  always_comb begin
    sum     = req_a + req_b;
    diff    = req_a - req_b;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (req_op)
      3'b000: alu_res = req_a & req_b;
      3'b001: alu_res = req_a | req_b;
      3'b010: begin
        alu_res = sum;
        alu_ovf = (req_a[WIDTH-1] == req_b[WIDTH-1]) && (sum[WIDTH-1] != req_a[WIDTH-1]);
      end
      3'b011: alu_res = req_a ^ req_b;
      3'b100: alu_res = ~(req_a | req_b);
      3'b101: alu_res = req_a << shamt;
      3'b110: begin
        alu_res = diff;
        alu_ovf = (req_a[WIDTH-1] != req_b[WIDTH-1]) && (diff[WIDTH-1] != req_a[WIDTH-1]);
      end
      default: alu_res = {{(WIDTH-1){1'b0}}, ($signed(req_a) < $signed(req_b))};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = is_shift ? SHIFT : RESP;
      SHIFT:   if (cnt_q == SH_W'(1)) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
  end

  // result_q doubles as the shift working register; zero flag tracks every update
  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    tag_d    = tag_q;
    cnt_d    = cnt_q;
    ops_d    = ops_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tag_d = req_tag;
          if (is_shift) begin
            result_d = req_a;
            cnt_d    = shamt;
            ovf_d    = 1'b0;
          end else begin
            result_d = alu_res;
            ovf_d    = alu_ovf;
          end
          zero_d = (result_d == '0);
        end
      end
      SHIFT: begin
        result_d = result_q << 1;
        cnt_d    = cnt_q - SH_W'(1);
        zero_d   = (result_d == '0);
      end
      RESP: begin
        if (rsp_ready && (ops_q != '1)) ops_d = ops_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      tag_q    <= '0;
      cnt_q    <= '0;
      ops_q    <= '0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      tag_q    <= tag_d;
      cnt_q    <= cnt_d;
      ops_q    <= ops_d;
    end
  end

  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_ovf    = ovf_q;
  assign rsp_tag    = tag_q;
  assign ops_done   = ops_q;

endmodule
